// File: rtl/pll_reset_sequencer.sv
// Staged reset release driven by a synchronized PLL lock indication.
// Optional lock-loss counter enabled by defining PLL_RST_LOSS_CNT_EN.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int NUM_RESETS         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic [NUM_RESETS-1:0] rst_out,
  output logic                  seq_done,
  output logic [7:0]            lock_loss_cnt
);

  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP_CYCLES + 1);
  localparam logic [SW-1:0]         STABLE_MAX   = SW'(LOCK_STABLE_CYCLES);
  localparam logic [GW-1:0]         GAP_LAST     = GW'(STAGE_GAP_CYCLES - 1);
  localparam logic [NUM_RESETS-1:0] ALL_ONES     = {NUM_RESETS{1'b1}};
  localparam logic [NUM_RESETS-1:0] LAST_PENDING = NUM_RESETS'(1) << (NUM_RESETS - 1);

  typedef enum logic [1:0] {ST_WAIT_LOCK, ST_RELEASE, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [SW-1:0]           stable_q, stable_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [NUM_RESETS-1:0]   rst_out_q, rst_out_d;
  logic                    seq_done_q, seq_done_d;
  logic                    locked_s;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_WAIT_LOCK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_LOCK:
        if (locked_s && stable_q == STABLE_MAX)
          state_d = (NUM_RESETS == 1) ? ST_RUN : ST_RELEASE;
      ST_RELEASE:
        if (!locked_s) state_d = ST_WAIT_LOCK;
        else if (gap_q == GAP_LAST && rst_out_q == LAST_PENDING) state_d = ST_RUN;
      ST_RUN:
        if (!locked_s) state_d = ST_WAIT_LOCK;
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // Counters default to zero so any state change clears them.
  always_comb begin
    rst_out_d  = rst_out_q;
    seq_done_d = seq_done_q;
    stable_d   = '0;
    gap_d      = '0;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          if (stable_q == STABLE_MAX) begin
            rst_out_d  = ALL_ONES << 1;
            seq_done_d = (NUM_RESETS == 1);
          end else begin
            stable_d = stable_q + SW'(1);
          end
        end
      end
      ST_RELEASE: begin
        if (!locked_s) begin
          rst_out_d  = ALL_ONES;
          seq_done_d = 1'b0;
        end else if (gap_q == GAP_LAST) begin
          rst_out_d  = rst_out_q << 1;
          seq_done_d = (rst_out_q == LAST_PENDING);
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          rst_out_d  = ALL_ONES;
          seq_done_d = 1'b0;
        end
      end
      default: begin
        rst_out_d  = ALL_ONES;
        seq_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      stable_q   <= '0;
      gap_q      <= '0;
      rst_out_q  <= ALL_ONES;
      seq_done_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      stable_q   <= stable_d;
      gap_q      <= gap_d;
      rst_out_q  <= rst_out_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign rst_out  = rst_out_q;
  assign seq_done = seq_done_q;

`ifdef PLL_RST_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (state_q == ST_RUN && !locked_s && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) loss_q <= 8'd0;
    else     loss_q <= loss_d;
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
